hazard_stall_controller: RTL and testbench

//  Sequences pipeline freeze/flush for the IF, ID, EX and MEM stages of the 5-stage core.
//  - Detects read-after-write (RAW) hazards between the ID source registers and the EX/MEM destinations.
//  - Holds the whole pipe while data memory is busy.
//  - Flushes wrong-path instructions after a taken branch.
//  - Keeps saturating stall/flush performance counters.

---
 rtl/hazard_stall_controller_if.sv | 45 ++++
 rtl/hazard_stall_controller.sv | 165 ++++++++++++++++
 tb/tb_hazard_stall_controller.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_controller_if.sv
// Pipeline hazard/stall control bundle: ID/EX/MEM hazard inputs, memory handshake,
// freeze/flush controls and performance counters.
interface hazard_stall_controller_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_src1;
    logic [REG_ADDR_W-1:0] id_src2;
    logic                  id_two_src;
    logic                  exe_wb_en;
    logic [REG_ADDR_W-1:0] exe_dest;
    logic                  exe_mem_read;
    logic                  mem_wb_en;
    logic [REG_ADDR_W-1:0] mem_dest;
    logic                  branch_taken;
    logic                  mem_req;
    logic                  mem_ack;

    logic                  pc_freeze;
    logic                  if_id_freeze;
    logic                  id_ex_bubble;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  pipe_freeze;
    logic                  mem_error;
    logic [1:0]            state_o;
    logic [31:0]           stall_cnt;
    logic [15:0]           flush_cnt;

    modport master (
        output id_valid, id_src1, id_src2, id_two_src,
        output exe_wb_en, exe_dest, exe_mem_read,
        output mem_wb_en, mem_dest, branch_taken, mem_req, mem_ack,
        input  pc_freeze, if_id_freeze, id_ex_bubble, if_id_flush, id_ex_flush,
        input  pipe_freeze, mem_error, state_o, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_two_src,
        input  exe_wb_en, exe_dest, exe_mem_read,
        input  mem_wb_en, mem_dest, branch_taken, mem_req, mem_ack,
        output pc_freeze, if_id_freeze, id_ex_bubble, if_id_flush, id_ex_flush,
        output pipe_freeze, mem_error, state_o, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Freeze/flush sequencer for the IF/ID/EX/MEM stages: RAW hazard stalls, data-memory
// wait with timeout, taken-branch flush penalty and saturating stall/flush counters.
module hazard_stall_controller #(
    parameter int REG_ADDR_W  = 5,
    parameter int FWD_EN      = 0,
    parameter int BR_PENALTY  = 2,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    hazard_stall_controller_if.slave hsc
);
    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_FLUSH    = 2'd2,
        S_ERROR    = 2'd3
    } state_e;

    localparam int                    TMO_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);
    localparam logic [1:0]            PEN_INIT = 2'(BR_PENALTY - 1);
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    state_e           state_q, state_d;
    logic [1:0]       pen_q, pen_d;
    logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
    logic [31:0]      stall_cnt_q;
    logic [15:0]      flush_cnt_q;

    logic [1:0]            wb_en;
    logic [REG_ADDR_W-1:0] dest [2];
    logic [1:0]            hz;
    logic                  raw;
    logic                  mem_busy;

    logic pc_frz, ifid_frz, pipe_frz, bubble, ifid_fl, idex_fl;
    logic stall_inc, flush_inc;

    // Index 0 = EX stage, index 1 = MEM stage.
    assign wb_en   = {hsc.mem_wb_en, hsc.exe_wb_en};
    assign dest[0] = hsc.exe_dest;
    assign dest[1] = hsc.mem_dest;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_hz
            assign hz[gi] = hsc.id_valid & wb_en[gi] & (dest[gi] != REG_ZERO) &
                            ((hsc.id_src1 == dest[gi]) |
                             (hsc.id_two_src & (hsc.id_src2 == dest[gi])));
        end
    endgenerate

    // With forwarding only a load in EX cannot be bypassed in time.
    assign raw      = (FWD_EN != 0) ? (hz[0] & hsc.exe_mem_read) : (hz[0] | hz[1]);
    assign mem_busy = hsc.mem_req & ~hsc.mem_ack;
    assign tmo_inc  = tmo_q + TMO_W'(1);

    always_comb begin
        state_d   = state_q;
        pen_d     = pen_q;
        tmo_d     = tmo_q;
        pc_frz    = 1'b0;
        ifid_frz  = 1'b0;
        pipe_frz  = 1'b0;
        bubble    = 1'b0;
        ifid_fl   = 1'b0;
        idex_fl   = 1'b0;
        flush_inc = 1'b0;

        case (state_q)
            S_RUN: begin
                if (mem_busy) begin
                    pc_frz   = 1'b1;
                    ifid_frz = 1'b1;
                    pipe_frz = 1'b1;
                    state_d  = S_MEM_WAIT;
                    // The requesting cycle already counts as the first waited cycle.
                    tmo_d    = TMO_W'(1);
                end else if (hsc.branch_taken) begin
                    ifid_fl   = 1'b1;
                    idex_fl   = 1'b1;
                    flush_inc = 1'b1;
                    if (BR_PENALTY > 1) begin
                        state_d = S_FLUSH;
                        pen_d   = PEN_INIT;
                    end
                end else if (raw) begin
                    pc_frz   = 1'b1;
                    ifid_frz = 1'b1;
                    bubble   = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                if (hsc.mem_ack) begin
                    state_d = S_RUN;
                end else begin
                    pc_frz   = 1'b1;
                    ifid_frz = 1'b1;
                    pipe_frz = 1'b1;
                    tmo_d    = tmo_inc;
                    if (tmo_inc == TMO_LAST) begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_FLUSH: begin
                if (mem_busy) begin
                    pc_frz   = 1'b1;
                    ifid_frz = 1'b1;
                    pipe_frz = 1'b1;
                    state_d  = S_MEM_WAIT;
                    tmo_d    = TMO_W'(1);
                    pen_d    = 2'd0;
                end else begin
                    ifid_fl = 1'b1;
                    pen_d   = pen_q - 2'd1;
                    if (pen_q == 2'd1) begin
                        state_d = S_RUN;
                    end
                end
            end
            default: begin
                pc_frz   = 1'b1;
                ifid_frz = 1'b1;
                pipe_frz = 1'b1;
            end
        endcase

        // ERROR keeps the freezes up but the counters are held.
        stall_inc = pc_frz & (state_q != S_ERROR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_RUN;
            pen_q       <= 2'd0;
            tmo_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            pen_q   <= pen_d;
            tmo_q   <= tmo_d;
            if (stall_inc && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_inc && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    // Controls are gated by reset so they clear the moment reset is asserted.
    assign hsc.pc_freeze    = pc_frz & rst;
    assign hsc.if_id_freeze = ifid_frz & rst;
    assign hsc.id_ex_bubble = bubble & rst;
    assign hsc.if_id_flush  = ifid_fl & rst;
    assign hsc.id_ex_flush  = idex_fl & rst;
    assign hsc.pipe_freeze  = pipe_frz & rst;
    assign hsc.mem_error    = (state_q == S_ERROR);
    assign hsc.state_o      = state_q;
    assign hsc.stall_cnt    = stall_cnt_q;
    assign hsc.flush_cnt    = flush_cnt_q;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: two instances (no forwarding / forwarding with
// different penalty and timeout) driven by identical directed and random stimulus.
module tb_hazard_stall_controller;
    localparam int AW = 5;
    // Control vector order: {pc_freeze, if_id_freeze, id_ex_bubble, if_id_flush, id_ex_flush, pipe_freeze}
    localparam logic [5:0] C_IDLE = 6'b000000;
    localparam logic [5:0] C_RAW  = 6'b111000;
    localparam logic [5:0] C_FRZ  = 6'b110001;
    localparam logic [5:0] C_BR   = 6'b000110;
    localparam logic [5:0] C_FL1  = 6'b000100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic id_valid, id_two_src, exe_wb_en, exe_mem_read, mem_wb_en;
    logic branch_taken, mem_req, mem_ack;
    logic [AW-1:0] id_src1, id_src2, exe_dest, mem_dest;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_stall_controller_if #(.REG_ADDR_W(AW)) if0 ();
    hazard_stall_controller_if #(.REG_ADDR_W(AW)) if1 ();

    assign if0.id_valid = id_valid;         assign if1.id_valid = id_valid;
    assign if0.id_src1 = id_src1;           assign if1.id_src1 = id_src1;
    assign if0.id_src2 = id_src2;           assign if1.id_src2 = id_src2;
    assign if0.id_two_src = id_two_src;     assign if1.id_two_src = id_two_src;
    assign if0.exe_wb_en = exe_wb_en;       assign if1.exe_wb_en = exe_wb_en;
    assign if0.exe_dest = exe_dest;         assign if1.exe_dest = exe_dest;
    assign if0.exe_mem_read = exe_mem_read; assign if1.exe_mem_read = exe_mem_read;
    assign if0.mem_wb_en = mem_wb_en;       assign if1.mem_wb_en = mem_wb_en;
    assign if0.mem_dest = mem_dest;         assign if1.mem_dest = mem_dest;
    assign if0.branch_taken = branch_taken; assign if1.branch_taken = branch_taken;
    assign if0.mem_req = mem_req;           assign if1.mem_req = mem_req;
    assign if0.mem_ack = mem_ack;           assign if1.mem_ack = mem_ack;

    hazard_stall_controller #(.REG_ADDR_W(AW), .FWD_EN(0), .BR_PENALTY(2), .MEM_TIMEOUT(64)) u_dut0 (
        .clk(clk), .rst(rst), .hsc(if0.slave));
    hazard_stall_controller #(.REG_ADDR_W(AW), .FWD_EN(1), .BR_PENALTY(1), .MEM_TIMEOUT(16)) u_dut1 (
        .clk(clk), .rst(rst), .hsc(if1.slave));

    logic [5:0]  obs_ctl   [2];
    logic [1:0]  obs_st    [2];
    logic [31:0] obs_stall [2];
    logic [15:0] obs_flush [2];
    logic        obs_err   [2];

    assign obs_ctl[0] = {if0.pc_freeze, if0.if_id_freeze, if0.id_ex_bubble,
                         if0.if_id_flush, if0.id_ex_flush, if0.pipe_freeze};
    assign obs_ctl[1] = {if1.pc_freeze, if1.if_id_freeze, if1.id_ex_bubble,
                         if1.if_id_flush, if1.id_ex_flush, if1.pipe_freeze};
    assign obs_st[0] = if0.state_o;       assign obs_st[1] = if1.state_o;
    assign obs_stall[0] = if0.stall_cnt;  assign obs_stall[1] = if1.stall_cnt;
    assign obs_flush[0] = if0.flush_cnt;  assign obs_flush[1] = if1.flush_cnt;
    assign obs_err[0] = if0.mem_error;    assign obs_err[1] = if1.mem_error;

    // Reference model state (per instance)
    bit          m_wait   [2];
    int          m_waited [2];
    int          m_fleft  [2];
    bit          m_err    [2];
    int unsigned m_stall  [2];
    int unsigned m_flush  [2];

    task automatic clear_inputs();
        id_valid = 0; id_two_src = 0; exe_wb_en = 0; exe_mem_read = 0; mem_wb_en = 0;
        branch_taken = 0; mem_req = 0; mem_ack = 0;
        id_src1 = '0; id_src2 = '0; exe_dest = '0; mem_dest = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_wait[k] = 0; m_waited[k] = 0; m_fleft[k] = 0; m_err[k] = 0;
            m_stall[k] = 0; m_flush[k] = 0;
        end
    endtask

    // Expected controls/state for this cycle, then advance the model one clock.
    task automatic model_cycle(input int k, output logic [5:0] ctl, output logic [1:0] st);
        int fwd, pen, tmo;
        bit hz_e, hz_m, raw, busy;
        fwd = (k == 0) ? 0 : 1;
        pen = (k == 0) ? 2 : 1;
        tmo = (k == 0) ? 64 : 16;
        hz_e = id_valid && exe_wb_en && (exe_dest != 0) &&
               ((id_src1 == exe_dest) || (id_two_src && (id_src2 == exe_dest)));
        hz_m = id_valid && mem_wb_en && (mem_dest != 0) &&
               ((id_src1 == mem_dest) || (id_two_src && (id_src2 == mem_dest)));
        raw  = (fwd != 0) ? (hz_e && exe_mem_read) : (hz_e || hz_m);
        busy = mem_req && !mem_ack;
        ctl = C_IDLE;
        st  = 2'd0;
        if (m_err[k]) begin
            st = 2'd3; ctl = C_FRZ;
        end else if (m_wait[k]) begin
            st = 2'd1;
            if (mem_ack) m_wait[k] = 0;
            else begin
                ctl = C_FRZ;
                m_waited[k]++;
                if (m_waited[k] >= tmo - 1) begin m_err[k] = 1; m_wait[k] = 0; end
            end
        end else if (m_fleft[k] > 0) begin
            st = 2'd2;
            if (busy) begin ctl = C_FRZ; m_wait[k] = 1; m_waited[k] = 1; m_fleft[k] = 0; end
            else begin ctl = C_FL1; m_fleft[k]--; end
        end else begin
            if (busy) begin
                ctl = C_FRZ; m_wait[k] = 1; m_waited[k] = 1;
            end else if (branch_taken) begin
                ctl = C_BR;
                if (m_flush[k] != 32'h0000_FFFF) m_flush[k]++;
                m_fleft[k] = pen - 1;
            end else if (raw) begin
                ctl = C_RAW;
            end
        end
        if (ctl[5] && (st != 2'd3) && (m_stall[k] != 32'hFFFF_FFFF)) m_stall[k]++;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        clear_inputs();
        id_valid = 1; id_src1 = 5; exe_dest = 5; exe_wb_en = 1; branch_taken = 1; mem_req = 1;
        #2;
        for (int k = 0; k < 2; k++) begin
            n_vec++; if (obs_ctl[k] !== C_IDLE) begin n_err++; $display("FAIL reset_ctl dut%0d got=%b exp=%b", k, obs_ctl[k], C_IDLE); end
            n_vec++; if (obs_st[k] !== 2'd0) begin n_err++; $display("FAIL reset_state dut%0d got=%0d exp=0", k, obs_st[k]); end
            n_vec++; if (obs_stall[k] !== 32'd0) begin n_err++; $display("FAIL reset_stall dut%0d got=%0d exp=0", k, obs_stall[k]); end
            n_vec++; if (obs_flush[k] !== 16'd0) begin n_err++; $display("FAIL reset_flush dut%0d got=%0d exp=0", k, obs_flush[k]); end
            n_vec++; if (obs_err[k] !== 1'b0) begin n_err++; $display("FAIL reset_err dut%0d got=%b exp=0", k, obs_err[k]); end
        end
        $display("test_reset done");
    endtask

    task automatic test_raw_stall();
        do_reset();
        id_valid = 1; id_src1 = 5; exe_dest = 5; exe_wb_en = 1; exe_mem_read = 0;
        @(negedge clk);
        n_vec++; if (obs_ctl[0] !== C_RAW) begin n_err++; $display("FAIL raw_nofwd_ctl got=%b exp=%b", obs_ctl[0], C_RAW); end
        n_vec++; if (obs_ctl[1] !== C_IDLE) begin n_err++; $display("FAIL raw_fwd_alu_ctl got=%b exp=%b", obs_ctl[1], C_IDLE); end
        next_cycle(); clear_inputs();
        @(negedge clk);
        n_vec++; if (obs_ctl[0] !== C_IDLE) begin n_err++; $display("FAIL raw_release_ctl got=%b exp=%b", obs_ctl[0], C_IDLE); end
        n_vec++; if (obs_stall[0] !== 32'd1) begin n_err++; $display("FAIL raw_stall_cnt0 got=%0d exp=1", obs_stall[0]); end
        n_vec++; if (obs_stall[1] !== 32'd0) begin n_err++; $display("FAIL raw_stall_cnt1 got=%0d exp=0", obs_stall[1]); end
        next_cycle();
        id_valid = 1; id_src1 = 5; exe_dest = 5; exe_wb_en = 1; exe_mem_read = 1;
        @(negedge clk);
        n_vec++; if (obs_ctl[1] !== C_RAW) begin n_err++; $display("FAIL raw_fwd_load_ctl got=%b exp=%b", obs_ctl[1], C_RAW); end
        next_cycle(); clear_inputs();
        @(negedge clk);
        n_vec++; if (obs_stall[1] !== 32'd1) begin n_err++; $display("FAIL load_use_stall_cnt1 got=%0d exp=1", obs_stall[1]); end
        n_vec++; if (obs_stall[0] !== 32'd2) begin n_err++; $display("FAIL load_use_stall_cnt0 got=%0d exp=2", obs_stall[0]); end
        $display("test_raw_stall done");
    endtask

    task automatic test_reg_zero();
        do_reset();
        id_valid = 1; id_src1 = 0; id_src2 = 0; id_two_src = 1;
        exe_wb_en = 1; exe_dest = 0; exe_mem_read = 1; mem_wb_en = 1; mem_dest = 0;
        @(negedge clk);
        n_vec++; if (obs_ctl[0] !== C_IDLE) begin n_err++; $display("FAIL reg0_ctl0 got=%b exp=%b", obs_ctl[0], C_IDLE); end
        n_vec++; if (obs_ctl[1] !== C_IDLE) begin n_err++; $display("FAIL reg0_ctl1 got=%b exp=%b", obs_ctl[1], C_IDLE); end
        next_cycle();
        exe_wb_en = 0; id_src2 = 7; mem_dest = 7;
        @(negedge clk);
        n_vec++; if (obs_ctl[0] !== C_RAW) begin n_err++; $display("FAIL mem_src2_ctl0 got=%b exp=%b", obs_ctl[0], C_RAW); end
        n_vec++; if (obs_ctl[1] !== C_IDLE) begin n_err++; $display("FAIL mem_src2_ctl1 got=%b exp=%b", obs_ctl[1], C_IDLE); end
        next_cycle();
        id_two_src = 0;
        @(negedge clk);
        n_vec++; if (obs_ctl[0] !== C_IDLE) begin n_err++; $display("FAIL src2_unused_ctl0 got=%b exp=%b", obs_ctl[0], C_IDLE); end
        $display("test_reg_zero done");
    endtask

    task automatic test_branch_flush();
        do_reset();
        id_valid = 1; id_src1 = 5; exe_dest = 5; exe_wb_en = 1; exe_mem_read = 1; branch_taken = 1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_vec++; if (obs_ctl[k] !== C_BR) begin n_err++; $display("FAIL br_t_ctl dut%0d got=%b exp=%b", k, obs_ctl[k], C_BR); end
        end
        next_cycle(); branch_taken = 0;
        @(negedge clk);
        n_vec++; if (obs_ctl[0] !== C_FL1) begin n_err++; $display("FAIL br_t1_ctl0 got=%b exp=%b", obs_ctl[0], C_FL1); end
        n_vec++; if (obs_st[0] !== 2'd2) begin n_err++; $display("FAIL br_t1_state0 got=%0d exp=2", obs_st[0]); end
        n_vec++; if (obs_ctl[1] !== C_RAW) begin n_err++; $display("FAIL br_t1_ctl1 got=%b exp=%b", obs_ctl[1], C_RAW); end
        next_cycle(); clear_inputs();
        @(negedge clk);
        n_vec++; if (obs_st[0] !== 2'd0) begin n_err++; $display("FAIL br_t2_state0 got=%0d exp=0", obs_st[0]); end
        n_vec++; if (obs_ctl[0] !== C_IDLE) begin n_err++; $display("FAIL br_t2_ctl0 got=%b exp=%b", obs_ctl[0], C_IDLE); end
        n_vec++; if (obs_flush[0] !== 16'd1) begin n_err++; $display("FAIL br_flush_cnt0 got=%0d exp=1", obs_flush[0]); end
        n_vec++; if (obs_flush[1] !== 16'd1) begin n_err++; $display("FAIL br_flush_cnt1 got=%0d exp=1", obs_flush[1]); end
        n_vec++; if (obs_stall[0] !== 32'd0) begin n_err++; $display("FAIL br_stall_cnt0 got=%0d exp=0", obs_stall[0]); end
        n_vec++; if (obs_stall[1] !== 32'd1) begin n_err++; $display("FAIL br_stall_cnt1 got=%0d exp=1", obs_stall[1]); end
        $display("test_branch_flush done");
    endtask

    task automatic test_mem_wait();
        logic [5:0] ec;
        logic [1:0] es;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            mem_req = 1; mem_ack = (c == 3); branch_taken = (c == 2);
            ec = (c < 3) ? C_FRZ : C_IDLE;
            es = (c == 0) ? 2'd0 : 2'd1;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_vec++; if (obs_ctl[k] !== ec) begin n_err++; $display("FAIL memwait_ctl dut%0d c=%0d got=%b exp=%b", k, c, obs_ctl[k], ec); end
                n_vec++; if (obs_st[k] !== es) begin n_err++; $display("FAIL memwait_state dut%0d c=%0d got=%0d exp=%0d", k, c, obs_st[k], es); end
            end
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_vec++; if (obs_stall[k] !== 32'd3) begin n_err++; $display("FAIL memwait_stall dut%0d got=%0d exp=3", k, obs_stall[k]); end
            n_vec++; if (obs_flush[k] !== 16'd0) begin n_err++; $display("FAIL memwait_flush dut%0d got=%0d exp=0", k, obs_flush[k]); end
            n_vec++; if (obs_st[k] !== 2'd0) begin n_err++; $display("FAIL memwait_exit dut%0d got=%0d exp=0", k, obs_st[k]); end
        end
        $display("test_mem_wait done");
    endtask

    task automatic test_mem_timeout();
        logic [1:0] e0, e1;
        do_reset();
        mem_req = 1; mem_ack = 0;
        for (int c = 0; c < 64; c++) begin
            e0 = (c == 0) ? 2'd0 : ((c < 63) ? 2'd1 : 2'd3);
            e1 = (c == 0) ? 2'd0 : ((c < 15) ? 2'd1 : 2'd3);
            @(negedge clk);
            n_vec++; if (obs_st[0] !== e0) begin n_err++; $display("FAIL tmo_state0 c=%0d got=%0d exp=%0d", c, obs_st[0], e0); end
            n_vec++; if (obs_st[1] !== e1) begin n_err++; $display("FAIL tmo_state1 c=%0d got=%0d exp=%0d", c, obs_st[1], e1); end
            n_vec++; if (obs_err[0] !== (c == 63)) begin n_err++; $display("FAIL tmo_err0 c=%0d got=%b exp=%b", c, obs_err[0], (c == 63)); end
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        n_vec++; if (obs_st[0] !== 2'd3) begin n_err++; $display("FAIL err_hold_state0 got=%0d exp=3", obs_st[0]); end
        n_vec++; if (obs_ctl[0] !== C_FRZ) begin n_err++; $display("FAIL err_hold_ctl0 got=%b exp=%b", obs_ctl[0], C_FRZ); end
        n_vec++; if (obs_stall[0] !== 32'd63) begin n_err++; $display("FAIL err_stall0 got=%0d exp=63", obs_stall[0]); end
        n_vec++; if (obs_stall[1] !== 32'd15) begin n_err++; $display("FAIL err_stall1 got=%0d exp=15", obs_stall[1]); end
        n_vec++; if (obs_err[1] !== 1'b1) begin n_err++; $display("FAIL err_flag1 got=%b exp=1", obs_err[1]); end
        $display("test_mem_timeout done");
    endtask

    task automatic test_async_reset();
        do_reset();
        mem_req = 1; mem_ack = 0;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        n_vec++; if (obs_st[0] !== 2'd1) begin n_err++; $display("FAIL pre_rst_state0 got=%0d exp=1", obs_st[0]); end
        #2 rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_vec++; if (obs_st[k] !== 2'd0) begin n_err++; $display("FAIL arst_state dut%0d got=%0d exp=0", k, obs_st[k]); end
            n_vec++; if (obs_ctl[k] !== C_IDLE) begin n_err++; $display("FAIL arst_ctl dut%0d got=%b exp=%b", k, obs_ctl[k], C_IDLE); end
            n_vec++; if (obs_stall[k] !== 32'd0) begin n_err++; $display("FAIL arst_stall dut%0d got=%0d exp=0", k, obs_stall[k]); end
        end
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        int ack_div;
        int unsigned es, ef;
        bit ee;
        logic [5:0] ec;
        logic [1:0] est;
        ack_div = 3;
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                model_reset();
                ack_div = ($urandom_range(0, 1) == 0) ? 3 : 40;
            end
            id_valid     = ($urandom_range(0, 3) != 0);
            id_src1      = AW'($urandom_range(0, 3));
            id_src2      = AW'($urandom_range(0, 3));
            id_two_src   = 1'($urandom_range(0, 1));
            exe_wb_en    = 1'($urandom_range(0, 1));
            exe_dest     = AW'($urandom_range(0, 3));
            exe_mem_read = 1'($urandom_range(0, 1));
            mem_wb_en    = 1'($urandom_range(0, 1));
            mem_dest     = AW'($urandom_range(0, 3));
            branch_taken = ($urandom_range(0, 7) == 0);
            mem_req      = ($urandom_range(0, 5) == 0);
            mem_ack      = ($urandom_range(0, ack_div - 1) == 0);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                es = m_stall[k]; ef = m_flush[k]; ee = m_err[k];
                model_cycle(k, ec, est);
                n_vec++; if (obs_ctl[k] !== ec) begin n_err++; $display("FAIL rnd_ctl dut%0d i=%0d got=%b exp=%b", k, i, obs_ctl[k], ec); end
                n_vec++; if (obs_st[k] !== est) begin n_err++; $display("FAIL rnd_state dut%0d i=%0d got=%0d exp=%0d", k, i, obs_st[k], est); end
                n_vec++; if (obs_stall[k] !== es) begin n_err++; $display("FAIL rnd_stall dut%0d i=%0d got=%0d exp=%0d", k, i, obs_stall[k], es); end
                n_vec++; if (obs_flush[k] !== 16'(ef)) begin n_err++; $display("FAIL rnd_flush dut%0d i=%0d got=%0d exp=%0d", k, i, obs_flush[k], ef); end
                n_vec++; if (obs_err[k] !== ee) begin n_err++; $display("FAIL rnd_err dut%0d i=%0d got=%b exp=%b", k, i, obs_err[k], ee); end
            end
            next_cycle();
        end
        $display("test_random done");
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_raw_stall();
        test_reg_zero();
        test_branch_flush();
        test_mem_wait();
        test_mem_timeout();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
